// File: rtl/trng_postproc_if.sv
// Interface bundle for the TRNG post-processor: raw-bit input, enable, the
// word output handshake and the health-alarm controls.
interface trng_postproc_if #(
  parameter int WORD_W = 32
);
  logic              en;
  logic              raw_bit;
  logic              raw_valid;
  logic [WORD_W-1:0] word_o;
  logic              word_valid;
  logic              word_ready;
  logic              rct_alarm;
  logic              alarm_clr;

  // master: the post-processor driving words; slave: the consumer/controller
  modport master (
    input  en, raw_bit, raw_valid, word_ready, alarm_clr,
    output word_o, word_valid, rct_alarm
  );

  modport slave (
    output en, raw_bit, raw_valid, word_ready, alarm_clr,
    input  word_o, word_valid, rct_alarm
  );
endinterface

// File: rtl/trng_postproc.sv
// Von Neumann debiaser feeding a word accumulator with a valid/ready output,
// guarded by a sticky repetition-count health alarm.
module trng_postproc #(
  parameter int WORD_W     = 32,
  parameter int RCT_CUTOFF = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  trng_postproc_if.master bus
);
  localparam int FILL_W = $clog2(WORD_W + 1);

  typedef enum logic {EMPTY, HAVE_FIRST} deb_state_t;

  deb_state_t        state;
  logic              first_bit;
  logic [WORD_W-1:0] acc;
  logic [FILL_W-1:0] fill;
  logic [WORD_W-1:0] word_q;
  logic              word_valid_q;
  logic              alarm_q;
  logic [7:0]        rep_cnt;
  logic              prev_bit;

  logic              accept;
  logic              emit;
  logic              can_load;
  logic              acc_full;
  logic              completes;
  logic              transfer;
  logic [WORD_W-1:0] acc_shift;
  logic [WORD_W-1:0] xfer_word;
  logic [7:0]        rep_next;

  // NOTE: every always_comb output gets an unconditional assignment, so no latch can be inferred.
  always_comb begin
    accept    = bus.en && bus.raw_valid;
    // Pair 10 emits 1 and pair 01 emits 0, so the emitted bit is always the first bit.
    emit      = accept && (state == HAVE_FIRST) && (first_bit != bus.raw_bit) && !alarm_q;
    can_load  = !word_valid_q || bus.word_ready;
    acc_full  = (fill == FILL_W'(WORD_W));
    acc_shift = {acc[WORD_W-2:0], first_bit};
    // A word completed this cycle bypasses the full state when the output is free.
    completes = !acc_full && emit && (fill == FILL_W'(WORD_W - 1));
    transfer  = !alarm_q && can_load && (acc_full || completes);
    xfer_word = acc_full ? acc : acc_shift;
    if (bus.raw_bit == prev_bit)
      rep_next = (rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1;
    else
      rep_next = 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= EMPTY;
      first_bit    <= 1'b0;
      acc          <= '0;
      fill         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      alarm_q      <= 1'b0;
      rep_cnt      <= 8'd0;
      prev_bit     <= 1'b0;
    end else begin
      if (!bus.en) begin
        state <= EMPTY;
      end else if (accept) begin
        if (state == EMPTY) begin
          state     <= HAVE_FIRST;
          first_bit <= bus.raw_bit;
        end else begin
          state <= EMPTY;
        end
      end

      // A stalled full accumulator drops new emitted bits until it can transfer.
      if (alarm_q) begin
        fill <= '0;
      end else if (acc_full) begin
        if (can_load) begin
          if (emit) begin
            acc  <= acc_shift;
            fill <= FILL_W'(1);
          end else begin
            fill <= '0;
          end
        end
      end else if (emit) begin
        acc  <= acc_shift;
        fill <= (completes && can_load) ? '0 : fill + 1'b1;
      end

      if (transfer) begin
        word_q       <= xfer_word;
        word_valid_q <= 1'b1;
      end else if (word_valid_q && bus.word_ready) begin
        word_valid_q <= 1'b0;
      end

      // Clear has priority over a trip in the same cycle.
      if (bus.alarm_clr) begin
        rep_cnt <= 8'd0;
        alarm_q <= 1'b0;
      end else if (accept) begin
        rep_cnt  <= rep_next;
        prev_bit <= bus.raw_bit;
        if (rep_next >= 8'(RCT_CUTOFF))
          alarm_q <= 1'b1;
      end
    end
  end

  assign bus.word_o     = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.rct_alarm  = alarm_q;
endmodule

// File: tb/tb_trng_postproc.sv
// Self-checking bench for trng_postproc: directed vector table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_trng_postproc;
  localparam int W   = 8;
  localparam int CUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trng_postproc_if #(.WORD_W(W)) bus ();

  trng_postproc #(.WORD_W(W), .RCT_CUTOFF(CUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit         m_have;
  bit         m_first;
  bit         q[$];
  logic [W-1:0] m_word;
  bit         m_valid;
  bit         m_alarm;
  int         m_cnt;
  bit         m_prev;

  typedef struct {
    logic [15:0] raw;
    logic [7:0]  exp_word;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] pack();
    logic [W-1:0] w;
    w = '0;
    foreach (q[i]) w = {w[W-2:0], q[i]};
    return w;
  endfunction

  function automatic void model_reset();
    m_have = 0; m_first = 0; q.delete();
    m_word = '0; m_valid = 0; m_alarm = 0; m_cnt = 0; m_prev = 0;
  endfunction

  // One clock of behaviour, evaluated from the inputs present before the edge.
  function automatic void model_step();
    bit acc_ok;
    bit e_valid;
    bit e_bit;
    bit loaded;
    bit can_load;
    acc_ok   = bus.en && bus.raw_valid;
    e_valid  = 0;
    e_bit    = 0;
    loaded   = 0;
    can_load = !m_valid || bus.word_ready;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (acc_ok) begin
      if (m_have) begin
        if (m_first != bus.raw_bit && !m_alarm) begin
          e_valid = 1;
          e_bit   = m_first;
        end
        m_have = 0;
      end else begin
        m_have  = 1;
        m_first = bus.raw_bit;
      end
    end
    if (!bus.en) m_have = 0;

    if (m_alarm) begin
      q.delete();
    end else if (q.size() == W) begin
      if (can_load) begin
        m_word = pack(); loaded = 1; q.delete();
        if (e_valid) q.push_back(e_bit);
      end
    end else begin
      if (e_valid) q.push_back(e_bit);
      if (q.size() == W && can_load) begin
        m_word = pack(); loaded = 1; q.delete();
      end
    end

    if (loaded) m_valid = 1;
    else if (m_valid && bus.word_ready) m_valid = 0;

    if (bus.alarm_clr) begin
      m_cnt = 0; m_alarm = 0;
    end else if (acc_ok) begin
      m_cnt  = (bus.raw_bit == m_prev) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 1;
      m_prev = bus.raw_bit;
      if (m_cnt >= CUT) m_alarm = 1;
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit rb, input bit rv,
                      input bit rdy, input bit clr);
    rst_n         = r;
    bus.en        = e;
    bus.raw_bit   = rb;
    bus.raw_valid = rv;
    bus.word_ready = rdy;
    bus.alarm_clr = clr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("model_valid", 64'(bus.word_valid), 64'(m_valid));
    check("model_word",  64'(bus.word_o),     64'(m_word));
    check("model_alarm", 64'(bus.rct_alarm),  64'(m_alarm));
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1, 1, bits[15-i], 1, rdy, 0);
  endtask

  task automatic idle(input bit rdy);
    step(1, 1, 0, 0, rdy, 0);
  endtask

  initial begin
    vecs[0] = '{raw: 16'h9A59, exp_word: 8'hB2};
    vecs[1] = '{raw: 16'hAAAA, exp_word: 8'hFF};
    vecs[2] = '{raw: 16'h5555, exp_word: 8'h00};
    vecs[3] = '{raw: 16'h9999, exp_word: 8'hAA};
    vecs[4] = '{raw: 16'h6666, exp_word: 8'h55};

    model_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("reset_valid", 64'(bus.word_valid), 64'd0);
    check("reset_word",  64'(bus.word_o),     64'd0);
    check("reset_alarm", 64'(bus.rct_alarm),  64'd0);

    // Table: 16 raw bits per word, word one cycle after the 16th bit
    for (int v = 0; v < 5; v++) begin
      feed(vecs[v].raw, 15, 1);
      check("vec_pre_valid", 64'(bus.word_valid), 64'd0);
      step(1, 1, vecs[v].raw[0], 1, 1, 0);
      check("vec_valid", 64'(bus.word_valid), 64'd1);
      check("vec_word",  64'(bus.word_o),     64'(vecs[v].exp_word));
    end

    // Non-emitting pairs 00/11 interleaved with 10
    feed(16'h2E2E, 16, 1);
    feed(16'h2E2E, 16, 1);
    check("skip_valid", 64'(bus.word_valid), 64'd1);
    check("skip_word",  64'(bus.word_o),     64'hFF);

    // Backpressure: hold first word, fill second, drop the rest
    idle(1);
    feed(16'h9A59, 16, 0);
    check("bp_first_valid", 64'(bus.word_valid), 64'd1);
    feed(16'h9999, 16, 0);
    feed(16'h5555, 16, 0);
    check("bp_hold_valid", 64'(bus.word_valid), 64'd1);
    check("bp_hold_word",  64'(bus.word_o),     64'hB2);
    idle(1);
    check("bp_second_valid", 64'(bus.word_valid), 64'd1);
    check("bp_second_word",  64'(bus.word_o),     64'hAA);
    idle(1);
    check("bp_drain_valid", 64'(bus.word_valid), 64'd0);

    // en=0 between the bits of a pair discards the first bit
    step(1, 1, 1, 1, 1, 0);
    step(1, 0, 1, 1, 1, 0);
    feed(16'h5555, 16, 1);
    check("en_valid", 64'(bus.word_valid), 64'd1);
    check("en_word",  64'(bus.word_o),     64'h00);

    // Repetition-count alarm, suppression, clear and recovery
    step(0, 0, 0, 0, 1, 0);
    feed(16'hE000, 3, 1);
    check("rct_pre", 64'(bus.rct_alarm), 64'd0);
    step(1, 1, 1, 1, 1, 0);
    check("rct_trip", 64'(bus.rct_alarm), 64'd1);
    feed(16'hAAAA, 16, 1);
    check("rct_no_word", 64'(bus.word_valid), 64'd0);
    check("rct_sticky",  64'(bus.rct_alarm),  64'd1);
    step(1, 1, 0, 0, 1, 1);
    check("rct_clr", 64'(bus.rct_alarm), 64'd0);
    feed(16'h9A59, 16, 1);
    check("rct_resume_valid", 64'(bus.word_valid), 64'd1);
    check("rct_resume_word",  64'(bus.word_o),     64'hB2);

    // Reset with a pending word and a partial fill
    feed(16'h6666, 16, 0);
    feed(16'hAAAA, 10, 0);
    check("mid_pending", 64'(bus.word_valid), 64'd1);
    step(0, 1, 0, 0, 0, 0);
    check("mid_rst_valid", 64'(bus.word_valid), 64'd0);
    check("mid_rst_word",  64'(bus.word_o),     64'd0);
    check("mid_rst_alarm", 64'(bus.rct_alarm),  64'd0);
    feed(16'hAAAA, 15, 1);
    check("mid_partial", 64'(bus.word_valid), 64'd0);
    step(1, 1, 0, 1, 1, 0);
    check("mid_full_valid", 64'(bus.word_valid), 64'd1);
    check("mid_full_word",  64'(bus.word_o),     64'hFF);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 19) != 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
